// File: rtl/ebus_pkg.sv
// Shared EBUS definitions: function codes, responder states, default device select.
// Imported by the EBUS responder, its interface and the parity helper.
package ebus_pkg;

  typedef enum logic [1:0] {
    OP_CONO  = 2'd0,
    OP_CONI  = 2'd1,
    OP_DATAO = 2'd2,
    OP_DATAI = 2'd3
  } ebus_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2
  } ebus_state_e;

  localparam logic [6:0] EBUS_DEV_ID_DEFAULT = 7'o070;

  // Function codes 4-7 have FCN[2] set and are never answered.
  function automatic logic fcn_valid(input logic [2:0] fcn);
    return ~fcn[2];
  endfunction

endpackage

// File: rtl/ebus_responder_if.sv
// EBUS bus bundle between the EBOX/EDP master and a device responder.
// master: drives CS/FCN/DEMAND/write data; slave: drives read data and XFER.
interface ebus_responder_if;
  logic [6:0]  ebusCS;
  logic [2:0]  ebusFCN;
  logic        ebusDEMAND;
  logic [0:35] ebusDataIn;
  logic        ebusParityIn;
  logic [0:35] ebusDataOut;
  logic        ebusParityOut;
  logic        ebusDataOE;
  logic        ebusXFER;

  modport master (
    output ebusCS, ebusFCN, ebusDEMAND,
    output ebusDataIn, ebusParityIn,
    input  ebusDataOut, ebusParityOut,
    input  ebusDataOE, ebusXFER
  );

  modport slave (
    input  ebusCS, ebusFCN, ebusDEMAND,
    input  ebusDataIn, ebusParityIn,
    output ebusDataOut, ebusParityOut,
    output ebusDataOE, ebusXFER
  );
endinterface

// File: rtl/ebus_parity.sv
// 36-bit odd-parity generator: par makes {data, par} hold an odd count of ones.
// Ports: data (in, 36, bits [0:35]), par (out, 1).
module ebus_parity (
  input  logic [0:35] data,
  output logic        par
);
  assign par = ~^data;
endmodule

// File: rtl/ebus_responder.sv
// EBUS device-side responder: decodes CS/FCN, answers DEMAND with XFER,
// accepts CONO/DATAO writes and sources CONI/DATAI reads.
// Ports: clk, CROBAR_N (async active-low reset), bus (ebus_responder_if.slave),
// conditions/dataOut/dataOutStrobe to the device core, dataIn/statusIn from it.
// Build option: EBUS_PARITY_EN enables bus parity check/generation and parErr.
module ebus_responder
  import ebus_pkg::*;
#(
  parameter logic [6:0]  DEV_ID      = EBUS_DEV_ID_DEFAULT,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         CROBAR_N,
  ebus_responder_if.slave bus,
  output logic [0:17]  conditions,
  output logic [0:35]  dataOut,
  output logic         dataOutStrobe,
  input  logic [0:35]  dataIn,
  input  logic [0:16]  statusIn
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  ebus_state_e state;
  ebus_op_e    op;
  logic [3:0]  cnt;
  logic        par_err;
  logic        par_bad;
  logic        accept;

`ifdef EBUS_PARITY_EN
  logic par_in_calc;
  logic par_out_calc;

  ebus_parity u_par_in (
    .data (bus.ebusDataIn),
    .par  (par_in_calc)
  );

  ebus_parity u_par_out (
    .data (bus.ebusDataOut),
    .par  (par_out_calc)
  );

  assign par_bad = par_in_calc != bus.ebusParityIn;
  assign bus.ebusParityOut = bus.ebusDataOE & par_out_calc;
`else
  logic unused_parity_in;

  assign unused_parity_in = bus.ebusParityIn;
  assign par_bad = 1'b0;
  assign bus.ebusParityOut = 1'b0;
`endif

  assign accept = bus.ebusDEMAND
                & (bus.ebusCS == DEV_ID)
                & fcn_valid(bus.ebusFCN);

  always_ff @(posedge clk or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      state           <= ST_IDLE;
      op              <= OP_CONO;
      cnt             <= '0;
      par_err         <= 1'b0;
      conditions      <= '0;
      dataOut         <= '0;
      dataOutStrobe   <= 1'b0;
      bus.ebusDataOut <= '0;
      bus.ebusDataOE  <= 1'b0;
      bus.ebusXFER    <= 1'b0;
    end else begin
      dataOutStrobe <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            op    <= ebus_op_e'(bus.ebusFCN[1:0]);
            cnt   <= WAIT_LD;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!bus.ebusDEMAND) begin
            state <= ST_IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Entry into XFER: all side effects land on this edge.
            state        <= ST_XFER;
            bus.ebusXFER <= 1'b1;
            unique case (1'b1)
              op == OP_CONO: begin
                if (par_bad) begin
                  par_err <= 1'b1;
                end else begin
                  conditions <= bus.ebusDataIn[18:35];
                  if (bus.ebusDataIn[0]) par_err <= 1'b0;
                end
              end
              op == OP_DATAO: begin
                if (par_bad) begin
                  par_err <= 1'b1;
                end else begin
                  dataOut       <= bus.ebusDataIn;
                  dataOutStrobe <= 1'b1;
                end
              end
              op == OP_CONI: begin
                bus.ebusDataOut <= {statusIn, par_err, conditions};
                bus.ebusDataOE  <= 1'b1;
              end
              op == OP_DATAI: begin
                bus.ebusDataOut <= dataIn;
                bus.ebusDataOE  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_XFER: begin
          if (!bus.ebusDEMAND) begin
            state           <= ST_IDLE;
            bus.ebusXFER    <= 1'b0;
            bus.ebusDataOE  <= 1'b0;
            bus.ebusDataOut <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ebus_responder.sv
// Directed bench for ebus_responder with a scoreboard of expected transfer
// results; checks handshake timing, register effects, aborts and reset.
module tb_ebus_responder;

`ifdef EBUS_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [35:0] val;
  } exp_t;

  logic        clk;
  logic        CROBAR_N;
  logic [0:17] conditions;
  logic [0:35] dataOut;
  logic        dataOutStrobe;
  logic [0:35] dataIn;
  logic [0:16] statusIn;

  ebus_responder_if bus ();

  ebus_responder #(
    .DEV_ID      (7'o070),
    .WAIT_CYCLES (2)
  ) dut (
    .clk           (clk),
    .CROBAR_N      (CROBAR_N),
    .bus           (bus),
    .conditions    (conditions),
    .dataOut       (dataOut),
    .dataOutStrobe (dataOutStrobe),
    .dataIn        (dataIn),
    .statusIn      (statusIn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  logic [35:0] m_cond;
  logic [35:0] m_dout;
  logic        m_perr;

  task automatic check(input string tag,
                       input logic [35:0] obs,
                       input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one DEMAND transaction; demand is dropped one cycle after XFER
  // is seen, or after max_cyc cycles if XFER never comes.
  task automatic run(input string tag,
                     input logic [6:0] cs,
                     input logic [2:0] fcn,
                     input logic [35:0] d,
                     input logic bad_par,
                     input int max_cyc,
                     output logic seen,
                     output int lat,
                     output int strobes);
    exp_t        e;
    logic        rd;
    logic [35:0] obs;
    rd = (fcn == 3'd1) || (fcn == 3'd3);
    @(negedge clk);
    bus.ebusCS       = cs;
    bus.ebusFCN      = fcn;
    bus.ebusDataIn   = d;
    bus.ebusParityIn = bad_par ? ^d : ~^d;
    bus.ebusDEMAND   = 1'b1;
    seen = 1'b0;
    lat = 0;
    strobes = 0;
    for (int i = 1; i <= max_cyc && !seen; i++) begin
      @(negedge clk);
      if (dataOutStrobe) strobes++;
      if (bus.ebusXFER) begin
        seen = 1'b1;
        lat = i - 1;
      end
    end
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      if (fcn == 3'd0) obs = {18'b0, conditions};
      else if (fcn == 3'd2) obs = dataOut;
      else obs = bus.ebusDataOut;
      check({tag, ":", e.tag}, obs, e.val);
      check({tag, ":oe"}, {35'b0, bus.ebusDataOE}, {35'b0, rd});
      if (rd)
        check({tag, ":par"}, {35'b0, bus.ebusParityOut},
              {35'b0, PAR_EN & ~^e.val});
      @(negedge clk);
      if (dataOutStrobe) strobes++;
      check({tag, ":hold_xfer"}, {35'b0, bus.ebusXFER}, 36'd1);
      if (rd) check({tag, ":hold_data"}, bus.ebusDataOut, e.val);
    end
    bus.ebusDEMAND = 1'b0;
    @(negedge clk);
    if (dataOutStrobe) strobes++;
    check({tag, ":rel_xfer"}, {35'b0, bus.ebusXFER}, 36'd0);
    check({tag, ":rel_oe"}, {35'b0, bus.ebusDataOE}, 36'd0);
    check({tag, ":rel_data"}, bus.ebusDataOut, 36'd0);
  endtask

  initial begin
    logic seen;
    int   lat;
    int   strobes;
    logic [35:0] d;

    CROBAR_N         = 1'b0;
    bus.ebusCS       = '0;
    bus.ebusFCN      = '0;
    bus.ebusDEMAND   = 1'b0;
    bus.ebusDataIn   = '0;
    bus.ebusParityIn = 1'b1;
    dataIn           = '0;
    statusIn         = '0;
    m_cond = '0;
    m_dout = '0;
    m_perr = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_xfer", {35'b0, bus.ebusXFER}, 36'd0);
    check("rst_oe", {35'b0, bus.ebusDataOE}, 36'd0);
    check("rst_data", bus.ebusDataOut, 36'd0);
    check("rst_par", {35'b0, bus.ebusParityOut}, 36'd0);
    check("rst_cond", {18'b0, conditions}, 36'd0);
    check("rst_dout", dataOut, 36'd0);
    check("rst_strobe", {35'b0, dataOutStrobe}, 36'd0);
    CROBAR_N = 1'b1;

    // DATAO write
    d = 36'h123456789;
    m_dout = d;
    sb.push_back('{"dout", m_dout});
    run("datao", 7'o070, 3'd2, d, 1'b0, 12, seen, lat, strobes);
    check("datao_seen", {35'b0, seen}, 36'd1);
    check("datao_lat", 36'(lat), 36'd3);
    check("datao_strobes", 36'(strobes), 36'd1);

    // DATAI read
    dataIn = 36'h987654321;
    sb.push_back('{"rdata", 36'h987654321});
    run("datai", 7'o070, 3'd3, 36'h0, 1'b0, 12, seen, lat, strobes);
    check("datai_seen", {35'b0, seen}, 36'd1);
    check("datai_lat", 36'(lat), 36'd3);
    check("datai_strobes", 36'(strobes), 36'd0);

    // CONO then CONI
    d = 36'h000000555;
    m_cond = {18'b0, d[17:0]};
    sb.push_back('{"cond", m_cond});
    run("cono", 7'o070, 3'd0, d, 1'b0, 12, seen, lat, strobes);
    check("cono_seen", {35'b0, seen}, 36'd1);
    statusIn = '0;
    sb.push_back('{"rdata", {statusIn, m_perr, m_cond[17:0]}});
    run("coni", 7'o070, 3'd1, 36'h0, 1'b0, 12, seen, lat, strobes);
    check("coni_seen", {35'b0, seen}, 36'd1);

    // Wrong device select and unanswered function code
    run("cs071", 7'o071, 3'd2, 36'hFFFFFFFFF, 1'b0, 20, seen, lat, strobes);
    check("cs071_seen", {35'b0, seen}, 36'd0);
    check("cs071_strobes", 36'(strobes), 36'd0);
    check("cs071_dout", dataOut, m_dout);
    run("fcn5", 7'o070, 3'd5, 36'hFFFFFFFFF, 1'b0, 20, seen, lat, strobes);
    check("fcn5_seen", {35'b0, seen}, 36'd0);
    check("fcn5_dout", dataOut, m_dout);
    check("fcn5_cond", {18'b0, conditions}, m_cond);

    // DEMAND dropped during WAIT
    run("abort", 7'o070, 3'd2, 36'h0DEADBEEF, 1'b0, 2, seen, lat, strobes);
    check("abort_seen", {35'b0, seen}, 36'd0);
    check("abort_strobes", 36'(strobes), 36'd0);
    check("abort_dout", dataOut, m_dout);

    // Reset while XFER is up during DATAI
    dataIn = 36'h0F0F0F0F0;
    @(negedge clk);
    bus.ebusCS     = 7'o070;
    bus.ebusFCN    = 3'd3;
    bus.ebusDEMAND = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.ebusXFER;
    end
    check("rstx_seen", {35'b0, seen}, 36'd1);
    CROBAR_N = 1'b0;
    #1;
    check("rstx_xfer", {35'b0, bus.ebusXFER}, 36'd0);
    check("rstx_oe", {35'b0, bus.ebusDataOE}, 36'd0);
    check("rstx_data", bus.ebusDataOut, 36'd0);
    check("rstx_dout", dataOut, 36'd0);
    check("rstx_cond", {18'b0, conditions}, 36'd0);
    @(negedge clk);
    bus.ebusDEMAND = 1'b0;
    CROBAR_N = 1'b1;
    m_cond = '0;
    m_dout = '0;
    m_perr = 1'b0;

    // Fresh transfer after reset shows the block restarted from IDLE
    d = 36'h0AAAA5555;
    m_dout = d;
    sb.push_back('{"dout", m_dout});
    run("post_rst", 7'o070, 3'd2, d, 1'b0, 12, seen, lat, strobes);
    check("post_rst_lat", 36'(lat), 36'd3);

    // DATAO with bad parity
    d = 36'h111111111;
    if (PAR_EN) m_perr = 1'b1;
    else m_dout = d;
    sb.push_back('{"dout", m_dout});
    run("badpar", 7'o070, 3'd2, d, 1'b1, 12, seen, lat, strobes);
    check("badpar_seen", {35'b0, seen}, 36'd1);
    check("badpar_strobes", 36'(strobes), PAR_EN ? 36'd0 : 36'd1);

    statusIn = 17'h1ABCD;
    sb.push_back('{"rdata", {statusIn, m_perr, m_cond[17:0]}});
    run("coni_perr", 7'o070, 3'd1, 36'h0, 1'b0, 12, seen, lat, strobes);
    check("coni_perr_seen", {35'b0, seen}, 36'd1);

    // CONO with bit 0 set clears the sticky parity error
    d = 36'h800000AAA;
    m_cond = {18'b0, d[17:0]};
    m_perr = 1'b0;
    sb.push_back('{"cond", m_cond});
    run("cono_clr", 7'o070, 3'd0, d, 1'b0, 12, seen, lat, strobes);
    statusIn = '0;
    sb.push_back('{"rdata", {statusIn, m_perr, m_cond[17:0]}});
    run("coni_clr", 7'o070, 3'd1, 36'h0, 1'b0, 12, seen, lat, strobes);
    check("coni_clr_seen", {35'b0, seen}, 36'd1);
    check("sb_empty", 36'(sb.size()), 36'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
